// File: rtl/btc_pkg.sv
// Shared constants and types for the bitcoin job dispatcher.
// Register word offsets, CTRL/STATUS bit positions and FSM encoding.
package btc_pkg;

  localparam logic [5:0] OFF_TAIL0  = 6'h08;
  localparam logic [5:0] OFF_TAIL1  = 6'h09;
  localparam logic [5:0] OFF_TAIL2  = 6'h0A;
  localparam logic [5:0] OFF_NSTART = 6'h0B;
  localparam logic [5:0] OFF_NEND   = 6'h0C;
  localparam logic [5:0] OFF_CTRL   = 6'h0D;
  localparam logic [5:0] OFF_STATUS = 6'h0E;
  localparam logic [5:0] OFF_RESULT = 6'h0F;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_IRQEN = 2;

  localparam int ST_FOUND = 1;
  localparam int ST_EXH   = 2;
  localparam int ST_OVF   = 3;

  localparam logic [31:0] NONCE_END_RST = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN
  } state_e;

  function automatic logic [31:0] merge_sel(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  sel
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/btc_job_dispatcher_if.sv
// Signal bundle around the dispatcher: firmware Wishbone side
// plus the hashing-core job/result handshake.
interface btc_job_dispatcher_if;

  logic         wbs_cyc_i;
  logic         wbs_stb_i;
  logic         wbs_we_i;
  logic [3:0]   wbs_sel_i;
  logic [31:0]  wbs_adr_i;
  logic [31:0]  wbs_dat_i;
  logic         wbs_ack_o;
  logic [31:0]  wbs_dat_o;
  logic [255:0] job_midstate_o;
  logic [95:0]  job_tail_o;
  logic [31:0]  job_nonce_o;
  logic         job_valid_o;
  logic         job_ready_i;
  logic         res_valid_i;
  logic         res_hit_i;
  logic [31:0]  res_nonce_i;
  logic         irq_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i,
    output wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  job_midstate_o, job_tail_o,
    input  job_nonce_o, job_valid_o,
    output job_ready_i,
    output res_valid_i, res_hit_i, res_nonce_i,
    input  irq_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i,
    input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output job_midstate_o, job_tail_o,
    output job_nonce_o, job_valid_o,
    input  job_ready_i,
    input  res_valid_i, res_hit_i, res_nonce_i,
    output irq_o
  );

endinterface

// File: rtl/btc_hit_fifo.sv
// Small synchronous FIFO for winning nonces; a push while full
// is accepted when a pop happens in the same cycle.
module btc_hit_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [31:0]   din,
  output logic [31:0]   dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_q];
  assign count   = cnt_q;

  always_comb begin
    wr_d  = wr_q + AW'(do_push);
    rd_d  = rd_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push)
                  - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/btc_job_dispatcher.sv
// Wishbone job front end: holds the header job, walks the nonce
// range through the core handshake and queues winning nonces.
module btc_job_dispatcher
  import btc_pkg::*;
#(
  parameter logic [31:0] BASE_ADR   = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         wbs_cyc_i,
  input  logic         wbs_stb_i,
  input  logic         wbs_we_i,
  input  logic [3:0]   wbs_sel_i,
  input  logic [31:0]  wbs_adr_i,
  input  logic [31:0]  wbs_dat_i,
  output logic         wbs_ack_o,
  output logic [31:0]  wbs_dat_o,
  output logic [255:0] job_midstate_o,
  output logic [95:0]  job_tail_o,
  output logic [31:0]  job_nonce_o,
  output logic         job_valid_o,
  input  logic         job_ready_i,
  input  logic         res_valid_i,
  input  logic         res_hit_i,
  input  logic [31:0]  res_nonce_i,
  output logic         irq_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e      state_q, state_d;
  logic [31:0] mid_q [8];
  logic [31:0] mid_d [8];
  logic [31:0] tail_q [3];
  logic [31:0] tail_d [3];
  logic [31:0] nstart_q, nstart_d;
  logic [31:0] nend_q, nend_d;
  logic [31:0] cur_q, cur_d;
  logic        irq_en_q, irq_en_d;
  logic        found_q, found_d;
  logic        exh_q, exh_d;
  logic        ovf_q, ovf_d;
  logic        apend_q, apend_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        irq_q, irq_d;

  logic          req, bus_hit, wr, rd, busy;
  logic          start, abort, cfg_wr, st_wr;
  logic [5:0]    off;
  logic [31:0]   rdata;
  logic [3:0]    cnt_view;
  logic          fifo_push, fifo_pop;
  logic          fifo_full, fifo_empty;
  logic [31:0]   fifo_dout;
  logic [CW-1:0] fifo_cnt;
  logic          unused_adr;

  assign req     = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign bus_hit = wbs_adr_i[31:8] == BASE_ADR[31:8];
  assign off     = wbs_adr_i[7:2];
  assign wr      = req & bus_hit & wbs_we_i;
  assign rd      = req & bus_hit & ~wbs_we_i;
  assign busy    = state_q != S_IDLE;
  assign cfg_wr  = wr & ~busy;
  assign st_wr   = wr & (off == OFF_STATUS) & wbs_sel_i[0];
  assign unused_adr = ^wbs_adr_i[1:0];

  assign start = wr & (off == OFF_CTRL) & wbs_sel_i[0]
               & wbs_dat_i[CTRL_START];
  assign abort = wr & (off == OFF_CTRL) & wbs_sel_i[0]
               & wbs_dat_i[CTRL_ABORT];

  assign fifo_pop = rd & (off == OFF_RESULT);
  assign cnt_view = (int'(fifo_cnt) > 15) ? 4'hF
                                          : 4'(fifo_cnt);

  btc_hit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (res_nonce_i),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_comb begin
    rdata = '0;
    case (off)
      OFF_TAIL0:  rdata = tail_q[0];
      OFF_TAIL1:  rdata = tail_q[1];
      OFF_TAIL2:  rdata = tail_q[2];
      OFF_NSTART: rdata = nstart_q;
      OFF_NEND:   rdata = nend_q;
      OFF_CTRL:   rdata = {29'd0, irq_en_q, 2'b00};
      OFF_STATUS: rdata = {24'd0, cnt_view, ovf_q,
                           exh_q, found_q, busy};
      OFF_RESULT: rdata = fifo_empty ? '0 : fifo_dout;
      default:
        if (off[5:3] == 3'b000) rdata = mid_q[off[2:0]];
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mid_d     = mid_q;
    tail_d    = tail_q;
    nstart_d  = nstart_q;
    nend_d    = nend_q;
    cur_d     = cur_q;
    irq_en_d  = irq_en_q;
    found_d   = found_q;
    exh_d     = exh_q;
    ovf_d     = ovf_q;
    apend_d   = apend_q;
    fifo_push = 1'b0;

    // job registers are frozen while a job runs
    if (cfg_wr && off[5:3] == 3'b000)
      mid_d[off[2:0]] = merge_sel(mid_q[off[2:0]],
                                  wbs_dat_i, wbs_sel_i);
    if (cfg_wr) begin
      case (off)
        OFF_TAIL0: tail_d[0] = merge_sel(tail_q[0],
                                         wbs_dat_i, wbs_sel_i);
        OFF_TAIL1: tail_d[1] = merge_sel(tail_q[1],
                                         wbs_dat_i, wbs_sel_i);
        OFF_TAIL2: tail_d[2] = merge_sel(tail_q[2],
                                         wbs_dat_i, wbs_sel_i);
        OFF_NSTART: nstart_d = merge_sel(nstart_q,
                                         wbs_dat_i, wbs_sel_i);
        OFF_NEND:   nend_d   = merge_sel(nend_q,
                                         wbs_dat_i, wbs_sel_i);
        default: ;
      endcase
    end

    if (wr && off == OFF_CTRL && wbs_sel_i[0])
      irq_en_d = wbs_dat_i[CTRL_IRQEN];

    if (st_wr) begin
      if (wbs_dat_i[ST_FOUND]) found_d = 1'b0;
      if (wbs_dat_i[ST_EXH])   exh_d   = 1'b0;
      if (wbs_dat_i[ST_OVF])   ovf_d   = 1'b0;
    end

    // flag sets below take precedence over the W1C above
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          cur_d   = nstart_q;
          exh_d   = 1'b0;
          apend_d = 1'b0;
        end
      end
      S_ISSUE: begin
        if (abort) apend_d = 1'b1;
        if (job_ready_i) begin
          apend_d = 1'b0;
          state_d = (apend_q | abort) ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        if (res_valid_i) begin
          if (res_hit_i) begin
            found_d   = 1'b1;
            fifo_push = 1'b1;
            if (fifo_full && !fifo_pop) ovf_d = 1'b1;
          end
          if (abort) begin
            state_d = S_IDLE;
          end else if (cur_q == nend_q) begin
            state_d = S_IDLE;
            exh_d   = 1'b1;
          end else begin
            cur_d   = cur_q + 32'd1;
            state_d = S_ISSUE;
          end
        end else if (abort) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (res_valid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack_d = req & bus_hit;
    dat_d = rd ? rdata : '0;
    irq_d = irq_en_q & (found_q | exh_q | ovf_q);
  end

  always_comb begin
    for (int i = 0; i < 8; i++)
      job_midstate_o[255-32*i -: 32] = mid_q[i];
    for (int i = 0; i < 3; i++)
      job_tail_o[95-32*i -: 32] = tail_q[i];
  end

  // the core shares the reset, so valid must fall with it
  assign job_valid_o = (state_q == S_ISSUE) & ~wb_rst_i;
  assign job_nonce_o = cur_q;
  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign irq_o       = irq_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      for (int i = 0; i < 8; i++) mid_q[i] <= '0;
      for (int i = 0; i < 3; i++) tail_q[i] <= '0;
      nstart_q <= '0;
      nend_q   <= NONCE_END_RST;
      cur_q    <= '0;
      irq_en_q <= 1'b0;
      found_q  <= 1'b0;
      exh_q    <= 1'b0;
      ovf_q    <= 1'b0;
      apend_q  <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mid_q    <= mid_d;
      tail_q   <= tail_d;
      nstart_q <= nstart_d;
      nend_q   <= nend_d;
      cur_q    <= cur_d;
      irq_en_q <= irq_en_d;
      found_q  <= found_d;
      exh_q    <= exh_d;
      ovf_q    <= ovf_d;
      apend_q  <= apend_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      irq_q    <= irq_d;
    end
  end

endmodule
